layer_pingpong_bridge: RTL and testbench

LAYER_PINGPONG_BRIDGE -- requirements
Module: layer_pingpong_bridge

---
 rtl/layer_pingpong_bridge.sv | 117 +++++++++++
 tb/tb_layer_pingpong_bridge.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/layer_pingpong_bridge.sv
// layer_pingpong_bridge: two-bank ping-pong buffer between a multi-lane feature-map producer and a single-word stream
// Ports: clk/res_n (async active-low reset); in_valid[k] flags a pixel for channel k carried on lane k%ProcessingElements
// of in_data; in_ready means a bank accepts writes; out_valid/out_ready/out_data/out_channel/out_last form the drain
// stream; image_done pulses when a bank fills; err_overflow/err_collision are sticky error flags.
module layer_pingpong_bridge #(
  parameter int NumberOfK = 4,
  parameter int ProcessingElements = 2,
  parameter int BitSize = 32,
  parameter int ImageWidth = 4,
  parameter int ReadMode = 0
) (
  input  logic                                       clk,
  input  logic                                       res_n,
  input  logic [NumberOfK-1:0]                       in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0] in_data,
  output logic                                       in_ready,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BitSize-1:0]                         out_data,
  output logic [$clog2(NumberOfK)-1:0]               out_channel,
  output logic                                       out_last,
  output logic                                       image_done,
  output logic                                       err_overflow,
  output logic                                       err_collision
);
  localparam int D = ImageWidth * ImageWidth;
  localparam int CW = $clog2(NumberOfK);
  localparam int PW = $clog2(D);
  localparam int NW = $clog2(D + 1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
  logic [BitSize-1:0] mem [2][NumberOfK][D];
  logic [NW-1:0] cnt [NumberOfK];
  bank_t st [2];
  logic wr_bank, rd_bank;
  logic [PW-1:0] rd_px, nxt_px;
  logic [CW-1:0] nxt_ch;
  logic [NumberOfK-1:0] coll, full, we;
  logic ovf, fill_done, hs, drain_done, other_free, px_end, ch_end, nxt_last;
  always_comb begin
    coll = '0;
    full = '0;
    for (int k = 0; k < NumberOfK; k++) begin
      full[k] = cnt[k] == NW'(D);
      for (int j = 0; j < NumberOfK; j++)
        if (j != k && (j % ProcessingElements) == (k % ProcessingElements) && in_valid[j] && in_valid[k]) coll[k] = 1'b1;
    end
    we = in_ready ? in_valid & ~coll & ~full : '0;
  end
  // Colliding bits are reported separately; while not ready every request counts as dropped.
  assign ovf = |(in_valid & (in_ready ? ~coll & full : {NumberOfK{1'b1}}));
  assign fill_done = in_ready & (&full);
  assign hs = out_valid & out_ready;
  assign drain_done = hs & out_last;
  // The other bank may be released on this very edge; reuse it immediately so no write is lost.
  assign other_free = st[~wr_bank] == EMPTY || (drain_done && rd_bank == ~wr_bank);
  always_comb begin
    px_end = rd_px == PW'(D - 1);
    ch_end = out_channel == CW'(NumberOfK - 1);
    nxt_px = (ReadMode == 0) ? (px_end ? '0 : rd_px + PW'(1)) : (ch_end ? rd_px + PW'(1) : rd_px);
    nxt_ch = (ReadMode == 0) ? (px_end ? out_channel + CW'(1) : out_channel) : (ch_end ? '0 : out_channel + CW'(1));
    nxt_last = nxt_ch == CW'(NumberOfK - 1) && nxt_px == PW'(D - 1);
  end
  always_ff @(posedge clk)
    for (int k = 0; k < NumberOfK; k++)
      if (we[k]) mem[wr_bank][k][PW'(cnt[k])] <= in_data[k % ProcessingElements];
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_channel <= '0;
      out_last <= 1'b0;
      image_done <= 1'b0;
      err_overflow <= 1'b0;
      err_collision <= 1'b0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_px <= '0;
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
    end else begin
      image_done <= fill_done;
      err_overflow <= err_overflow | ovf;
      err_collision <= err_collision | (|coll);
      for (int k = 0; k < NumberOfK; k++) cnt[k] <= fill_done ? '0 : cnt[k] + NW'(we[k]);
      if (|we && st[wr_bank] == EMPTY) st[wr_bank] <= FILLING;
      if (fill_done) begin
        st[wr_bank] <= FULL;
        if (other_free) wr_bank <= ~wr_bank;
        else in_ready <= 1'b0;
      end else if (!in_ready && drain_done) begin
        wr_bank <= rd_bank;
        in_ready <= 1'b1;
      end
      if (hs) begin
        if (out_last) begin
          st[rd_bank] <= EMPTY;
          rd_bank <= ~rd_bank;
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end else begin
          out_data <= mem[rd_bank][nxt_ch][nxt_px];
          out_channel <= nxt_ch;
          rd_px <= nxt_px;
          out_last <= nxt_last;
        end
      end else if (!out_valid && st[rd_bank] == FULL) begin
        st[rd_bank] <= DRAINING;
        out_valid <= 1'b1;
        out_data <= mem[rd_bank][0][0];
        out_channel <= '0;
        rd_px <= '0;
        out_last <= NumberOfK * D == 1;
      end
    end
endmodule

// File: tb/tb_layer_pingpong_bridge.sv
// tb_layer_pingpong_bridge: directed checks of both readout orders, stalls, overflow, collision and reset
module tb_layer_pingpong_bridge;
  logic clk = 0, res_n = 0, out_ready = 0;
  logic [3:0] in_valid = '0;
  logic [1:0][31:0] in_data = '0;
  logic in_ready0, out_valid0, out_last0, image_done0, err_ovf0, err_col0;
  logic in_ready1, out_valid1, out_last1, image_done1, err_ovf1, err_col1;
  logic [31:0] out_data0, out_data1;
  logic [1:0] out_channel0, out_channel1;
  int total = 0, bad = 0, idone = 0;
  int unsigned bases [2];
  always #5 clk = ~clk;
  layer_pingpong_bridge #(.NumberOfK(4), .ProcessingElements(2), .BitSize(32), .ImageWidth(2), .ReadMode(0)) dut0 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_channel(out_channel0),
    .out_last(out_last0), .image_done(image_done0), .err_overflow(err_ovf0), .err_collision(err_col0));
  layer_pingpong_bridge #(.NumberOfK(4), .ProcessingElements(2), .BitSize(32), .ImageWidth(2), .ReadMode(1)) dut1 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_channel(out_channel1),
    .out_last(out_last1), .image_done(image_done1), .err_overflow(err_ovf1), .err_collision(err_col1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset();
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_channel", out_channel0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_image_done", image_done0, 0);
    chk("rst_err_overflow", err_ovf0, 0);
    chk("rst_err_collision", err_col0, 0);
    chk("rst_in_ready1", in_ready1, 1);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_image_done1", image_done1, 0);
    chk("rst_errs1", {err_ovf1, err_col1}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    res_n = 0;
    in_valid = '0;
    out_ready = 0;
    idone = 0;
    @(negedge clk);
    res_n = 1;
  endtask
  // channel k pixel p carries base + 16k + p; channels 0/1 go out together, then 2/3
  task automatic fill(input int base);
    for (int p = 0; p < 4; p++)
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        in_valid = g ? 4'b1100 : 4'b0011;
        in_data[0] = 32'(base + 32 * g + p);
        in_data[1] = 32'(base + 32 * g + 16 + p);
      end
    @(negedge clk);
    in_valid = '0;
  endtask
  function automatic logic [31:0] exp_word(input int i, input bit mode);
    int j = i % 16;
    return 32'(bases[i / 16] + (mode ? 16 * (j % 4) + j / 4 : 16 * (j / 4) + j % 4));
  endfunction
  task automatic drain(input int n, input bit rnd, input bit chk_ir);
    int i = 0;
    int cyc = 0;
    bit ir_seen = 0;
    while (i < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (image_done0) begin
        idone++;
        chk("valid_at_done", out_valid0, 0);
      end
      if (chk_ir && i == 15 && out_valid0) chk("in_ready_held", in_ready0, 0);
      if (chk_ir && i == 16 && !ir_seen) begin
        chk("in_ready_freed", in_ready0, 1);
        ir_seen = 1;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid0) begin
        chk("data0", out_data0, exp_word(i, 0));
        chk("chan0", out_channel0, 32'((i % 16) / 4));
        chk("last0", out_last0, 32'(i % 16 == 15));
      end
      if (out_valid1) begin
        chk("data1", out_data1, exp_word(i, 1));
        chk("chan1", out_channel1, 32'(i % 4));
        chk("last1", out_last1, 32'(i % 16 == 15));
      end
      if (out_valid0 && out_ready) i++;
    end
    chk("drain_words", i, n);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_reset();
    res_n = 1;
    bases[0] = 0;
    bases[1] = 256;
    // both readout orders, out_ready held high
    fill(0);
    drain(16, 0, 0);
    chk("image_done_once", idone, 1);
    chk("no_errors", {err_ovf0, err_col0}, 0);
    // lane collision, then a normal fill under random backpressure
    do_reset();
    @(negedge clk);
    in_valid = 4'b0101;
    in_data[0] = 32'hDEAD;
    @(negedge clk);
    in_valid = '0;
    chk("collision_flag", err_col0, 1);
    chk("collision_no_ovf", err_ovf0, 0);
    chk("collision_ready", in_ready0, 1);
    fill(0);
    drain(16, 1, 0);
    chk("image_done_once_rnd", idone, 1);
    // reset while draining after word 5, then a fresh image
    do_reset();
    fill(0);
    drain(6, 0, 0);
    @(negedge clk);
    res_n = 0;
    #1;
    check_reset();
    @(negedge clk);
    res_n = 1;
    bases[0] = 64;
    fill(64);
    drain(16, 0, 0);
    // both banks full under backpressure, overflow, then ordered drain
    do_reset();
    bases[0] = 0;
    fill(0);
    repeat (2) @(negedge clk);
    chk("stall_valid", out_valid0, 1);
    chk("stall_word0", out_data0, 0);
    chk("ready_after_a", in_ready0, 1);
    fill(256);
    repeat (2) @(negedge clk);
    chk("ready_low_both_full", in_ready0, 0);
    chk("no_ovf_yet", err_ovf0, 0);
    @(negedge clk);
    in_valid = 4'b0001;
    @(negedge clk);
    in_valid = '0;
    chk("overflow_flag", err_ovf0, 1);
    chk("stall_data_held", out_data0, 0);
    drain(32, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
